// File: rtl/stall_flush_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// stall_flush_ctrl_pkg
//   Shared defines for the pipeline stall/flush controller:
//     - per-stage stall vector encodings (bit0 PC ... bit5 WB, 1 = stop)
//     - exception codes and the common exception vector
//     - controller FSM state encoding
//     - helper that selects the redirect target for an exception code
// -----------------------------------------------------------------------------
package stall_flush_ctrl_pkg;

   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

   // Stall vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
   localparam int unsigned STALL_W       = 6;
   localparam logic [5:0]  STALL_NONE    = 6'b000000;
   localparam logic [5:0]  STALL_FROM_IF  = 6'b000011;
   localparam logic [5:0]  STALL_FROM_ID  = 6'b000111;
   localparam logic [5:0]  STALL_FROM_EX  = 6'b001111;
   localparam logic [5:0]  STALL_FROM_MEM = 6'b011111;

   // Exception codes delivered by the MEM stage; zero means no exception.
   localparam logic [31:0] EXC_NONE      = 32'h0000_0000;
   localparam logic [31:0] EXC_ERET      = 32'h0000_000e;

   // Common handler entry point for every exception except eret.
   localparam logic [31:0] EXC_VECTOR    = 32'h0000_0020;

   // Refill counter width; REFILL_CYCLES must fit 1..15.
   localparam int unsigned REFILL_CNT_W  = 4;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_REFILL = 1'b1
   } ctrl_state_e;

   // eret returns to the saved EPC; everything else enters the handler.
   function automatic logic [31:0] exc_target(input logic [31:0] excepttype,
                                              input logic [31:0] epc);
      logic [31:0] target;
      if (excepttype == EXC_ERET) begin
         target = epc;
      end else begin
         target = EXC_VECTOR;
      end
      return target;
   endfunction

endpackage

// File: rtl/stall_flush_ctrl_stall_encoder.sv
// -----------------------------------------------------------------------------
// stall_encoder
//   Purely combinational priority encoder turning the four stage stall
//   requests into a per-stage stall vector. A request from a later stage
//   also freezes every earlier stage; priority is mem > ex > id > if.
//
//   Ports:
//     stallreq_from_if_i   in   instruction-bus stall request
//     stallreq_from_id_i   in   decode-stage stall request
//     stallreq_from_ex_i   in   execute-stage stall request
//     stallreq_from_mem_i  in   data-bus stall request
//     stall_o[5:0]         out  stall vector (bit0 PC ... bit5 WB)
// -----------------------------------------------------------------------------
module stall_encoder
   import stall_flush_ctrl_pkg::*;
(
   input  logic       stallreq_from_if_i,
   input  logic       stallreq_from_id_i,
   input  logic       stallreq_from_ex_i,
   input  logic       stallreq_from_mem_i,
   output logic [5:0] stall_o
);

   always_comb begin
      stall_o = STALL_NONE;
      if (stallreq_from_mem_i) begin
         stall_o = STALL_FROM_MEM;
      end else if (stallreq_from_ex_i) begin
         stall_o = STALL_FROM_EX;
      end else if (stallreq_from_id_i) begin
         stall_o = STALL_FROM_ID;
      end else if (stallreq_from_if_i) begin
         stall_o = STALL_FROM_IF;
      end
   end

endmodule

// File: rtl/stall_flush_ctrl.sv
// -----------------------------------------------------------------------------
// stall_flush_ctrl
//   Pipeline stall/flush controller. In RUN, a nonzero exception code from the
//   MEM stage flushes the pipeline and redirects the PC in the same cycle,
//   overriding any stall request. The controller then sits in REFILL for
//   REFILL_CYCLES clock cycles during which exceptions are masked while the
//   pipeline refills. Outside a flush the stall vector comes from the priority
//   encoder.
//
//   Handshake note: there is no valid/ready pairing here. Every input is a
//   level sampled each cycle; stall/flush/new_pc are combinational responses
//   to the current inputs and state, and new_pc is meaningful only while
//   flush=1 (otherwise it reads as zero).
//
//   Parameter:
//     REFILL_CYCLES      post-flush exception-mask window in cycles (1..15)
//
//   Ports:
//     clk                in   clock, all state updates on rising edge
//     rst                in   synchronous active-high reset
//     stallreq_from_if   in   instruction-bus stall request
//     stallreq_from_id   in   decode-stage stall request
//     stallreq_from_ex   in   execute-stage stall request (mul/div)
//     stallreq_from_mem  in   data-bus stall request
//     excepttype_i[31:0] in   exception code from MEM stage, 0 = none
//     cp0_epc_i[31:0]    in   current CP0 EPC
//     stall[5:0]         out  per-stage stall vector (bit0 PC ... bit5 WB)
//     flush              out  pipeline-register flush
//     new_pc[31:0]       out  redirect target, valid while flush=1
//     refill_o           out  high while in REFILL; doubles as the FSM state
//                             observation point (one-bit state)
//
//   Optional build macro STALL_PERF_CNT_EN adds:
//     stall_cycles_o[31:0] out cycles with stall != 0 (wraps, cleared by rst)
//     flush_count_o[31:0]  out cycles with flush = 1  (wraps, cleared by rst)
// -----------------------------------------------------------------------------
module stall_flush_ctrl
   import stall_flush_ctrl_pkg::*;
#(
   parameter int unsigned REFILL_CYCLES = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_if,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        refill_o
`ifdef STALL_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles_o,
   output logic [31:0] flush_count_o
`endif
);

   // Counter is loaded with N-1 so that REFILL lasts exactly N cycles:
   // the state leaves REFILL on the cycle the counter is already zero.
   localparam logic [REFILL_CNT_W-1:0] REFILL_LOAD =
      REFILL_CNT_W'(REFILL_CYCLES - 1);

   ctrl_state_e              state_q, state_d;
   logic [REFILL_CNT_W-1:0]  cnt_q, cnt_d;
   logic [5:0]               enc_stall;

   stall_encoder u_stall_encoder (
      .stallreq_from_if_i  (stallreq_from_if),
      .stallreq_from_id_i  (stallreq_from_id),
      .stallreq_from_ex_i  (stallreq_from_ex),
      .stallreq_from_mem_i (stallreq_from_mem),
      .stall_o             (enc_stall)
   );

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = enc_stall;
      flush   = 1'b0;
      new_pc  = ZERO_WORD;

      unique case (state_q)
         ST_RUN: begin
            if (excepttype_i != EXC_NONE) begin
               // Exception beats every stall request: the flushed pipeline
               // registers must not be held.
               flush   = 1'b1;
               stall   = STALL_NONE;
               new_pc  = exc_target(excepttype_i, cp0_epc_i);
               state_d = ST_REFILL;
               cnt_d   = REFILL_LOAD;
            end
         end
         ST_REFILL: begin
            // Exceptions are masked here; the window counts raw clock
            // cycles, so it keeps running even while the pipe is stalled.
            if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase

      // Reset quiets the pipeline control outputs immediately.
      if (rst) begin
         stall  = STALL_NONE;
         flush  = 1'b0;
         new_pc = ZERO_WORD;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign refill_o = (state_q == ST_REFILL);

`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] flush_count_q, flush_count_d;

   // Counted from the final (reset-gated) outputs; wrap naturally at 2^32.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      if (stall != STALL_NONE) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (flush) begin
         flush_count_d = flush_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         flush_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stall_flush_ctrl
//   Directed bench for stall_flush_ctrl (REFILL_CYCLES = 2). Each step drives
//   the inputs on the falling edge, queues the outputs it requires, and checks
//   them shortly after, well before the next rising edge.
// -----------------------------------------------------------------------------
module tb_stall_flush_ctrl;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stallreq_from_if  = 1'b0;
   logic        stallreq_from_id  = 1'b0;
   logic        stallreq_from_ex  = 1'b0;
   logic        stallreq_from_mem = 1'b0;
   logic [31:0] excepttype_i = 32'h0;
   logic [31:0] cp0_epc_i    = 32'h0;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        refill_o;
`ifdef STALL_PERF_CNT_EN
   logic [31:0] stall_cycles_o;
   logic [31:0] flush_count_o;
`endif

   always #5 clk = ~clk;

   stall_flush_ctrl #(.REFILL_CYCLES(2)) dut (
      .clk               (clk),
      .rst               (rst),
      .stallreq_from_if  (stallreq_from_if),
      .stallreq_from_id  (stallreq_from_id),
      .stallreq_from_ex  (stallreq_from_ex),
      .stallreq_from_mem (stallreq_from_mem),
      .excepttype_i      (excepttype_i),
      .cp0_epc_i         (cp0_epc_i),
      .stall             (stall),
      .flush             (flush),
      .new_pc            (new_pc),
      .refill_o          (refill_o)
`ifdef STALL_PERF_CNT_EN
      ,
      .stall_cycles_o    (stall_cycles_o),
      .flush_count_o     (flush_count_o)
`endif
   );

   // ---------------- scoreboard ----------------
   // Entry layout: {stall[5:0], flush, new_pc[31:0], refill_o}
   localparam int W = 40;
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;

   // Independent priority reference: req = {mem, ex, id, if}.
   function automatic logic [5:0] ref_stall(input logic [3:0] req);
      if (req[3])      return 6'b011111;
      else if (req[2]) return 6'b001111;
      else if (req[1]) return 6'b000111;
      else if (req[0]) return 6'b000011;
      else             return 6'b000000;
   endfunction

   task automatic check_outputs(input string tag);
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s: scoreboard empty, observed stall=%b flush=%b", tag, stall, flush);
         return;
      end
      e = exp_q.pop_front();
      checks++;
      assert (stall === e[39:34]) else begin
         errors++;
         $error("FAIL %s.stall: observed %b expected %b", tag, stall, e[39:34]);
      end
      checks++;
      assert (flush === e[33]) else begin
         errors++;
         $error("FAIL %s.flush: observed %b expected %b", tag, flush, e[33]);
      end
      checks++;
      assert (new_pc === e[32:1]) else begin
         errors++;
         $error("FAIL %s.new_pc: observed %h expected %h", tag, new_pc, e[32:1]);
      end
      checks++;
      assert (refill_o === e[0]) else begin
         errors++;
         $error("FAIL %s.refill_o: observed %b expected %b", tag, refill_o, e[0]);
      end
   endtask

   // ---------------- driver ----------------
   // req = {mem, ex, id, if}
   task automatic step(input string tag, input logic r, input logic [3:0] req,
                       input logic [31:0] exc, input logic [31:0] epc,
                       input logic [5:0] e_stall, input logic e_flush,
                       input logic [31:0] e_pc, input logic e_refill);
      @(negedge clk);
      rst               = r;
      stallreq_from_mem = req[3];
      stallreq_from_ex  = req[2];
      stallreq_from_id  = req[1];
      stallreq_from_if  = req[0];
      excepttype_i      = exc;
      cp0_epc_i         = epc;
      exp_q.push_back({e_stall, e_flush, e_pc, e_refill});
      #2;
      check_outputs(tag);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [3:0] rq;

      // Reset holds outputs quiet whatever the inputs say.
      step("rst_quiet",  1'b1, 4'b1111, 32'h8,  32'h1234, 6'b000000, 1'b0, 32'h0, 1'b0);
      step("idle",       1'b0, 4'b0000, 32'h0,  32'h0,    6'b000000, 1'b0, 32'h0, 1'b0);

      // Priority encoding in RUN.
      step("ex_only",    1'b0, 4'b0100, 32'h0,  32'h0,    6'b001111, 1'b0, 32'h0, 1'b0);
      step("if_only",    1'b0, 4'b0001, 32'h0,  32'h0,    6'b000011, 1'b0, 32'h0, 1'b0);
      step("id_only",    1'b0, 4'b0010, 32'h0,  32'h0,    6'b000111, 1'b0, 32'h0, 1'b0);
      step("id_if",      1'b0, 4'b0011, 32'h0,  32'h0,    6'b000111, 1'b0, 32'h0, 1'b0);
      step("mem_only",   1'b0, 4'b1000, 32'h0,  32'h0,    6'b011111, 1'b0, 32'h0, 1'b0);
      step("all_req",    1'b0, 4'b1111, 32'h0,  32'h0,    6'b011111, 1'b0, 32'h0, 1'b0);

      // eret with mem stall: flush wins, target is EPC; then 2 refill cycles
      // during which the still-present eret is ignored.
      step("eret_flush", 1'b0, 4'b1000, 32'he,  32'h1234, 6'b000000, 1'b1, 32'h1234, 1'b0);
      step("eret_rf1",   1'b0, 4'b1000, 32'he,  32'h1234, 6'b011111, 1'b0, 32'h0, 1'b1);
      step("eret_rf2",   1'b0, 4'b0000, 32'h0,  32'h1234, 6'b000000, 1'b0, 32'h0, 1'b1);
      step("eret_run",   1'b0, 4'b0000, 32'h0,  32'h0,    6'b000000, 1'b0, 32'h0, 1'b0);

      // Exception held 4 cycles: flush, refill, refill, flush again.
      step("hold_c0",    1'b0, 4'b0000, 32'h8,  32'h5555, 6'b000000, 1'b1, 32'h20, 1'b0);
      step("hold_c1",    1'b0, 4'b0000, 32'h8,  32'h5555, 6'b000000, 1'b0, 32'h0, 1'b1);
      step("hold_c2",    1'b0, 4'b0000, 32'h8,  32'h5555, 6'b000000, 1'b0, 32'h0, 1'b1);
      step("hold_c3",    1'b0, 4'b0000, 32'h8,  32'h5555, 6'b000000, 1'b1, 32'h20, 1'b0);

      // Reset in the first refill cycle aborts the window.
      step("rst_refill", 1'b1, 4'b0100, 32'h8,  32'h5555, 6'b000000, 1'b0, 32'h0, 1'b1);
      step("post_rst",   1'b0, 4'b0000, 32'hc,  32'h5555, 6'b000000, 1'b1, 32'h20, 1'b0);

      // Window counts cycles even while stalled.
      step("stl_rf1",    1'b0, 4'b0100, 32'h4,  32'h0,    6'b001111, 1'b0, 32'h0, 1'b1);
      step("stl_rf2",    1'b0, 4'b0100, 32'h4,  32'h0,    6'b001111, 1'b0, 32'h0, 1'b1);
      step("stl_run",    1'b0, 4'b0100, 32'h0,  32'h0,    6'b001111, 1'b0, 32'h0, 1'b0);

      // Random request mixes in RUN, no exceptions.
      for (int i = 0; i < 12; i++) begin
         rq = 4'($urandom_range(0, 15));
         step("rand_req", 1'b0, rq, 32'h0, $urandom, ref_stall(rq), 1'b0, 32'h0, 1'b0);
      end

      // Eret with a random EPC under a random stall, then let refill finish.
      rq = 4'($urandom_range(1, 15));
      begin
         logic [31:0] epc;
         epc = $urandom;
         step("eret_rand",  1'b0, rq, 32'he, epc, 6'b000000, 1'b1, epc, 1'b0);
         step("eret_rand1", 1'b0, rq, 32'h0, epc, ref_stall(rq), 1'b0, 32'h0, 1'b1);
         step("eret_rand2", 1'b0, rq, 32'h0, epc, ref_stall(rq), 1'b0, 32'h0, 1'b1);
      end

`ifdef STALL_PERF_CNT_EN
      // 5 stalled cycles and one flush after a fresh reset.
      step("perf_rst",   1'b1, 4'b0000, 32'h0,  32'h0,    6'b000000, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step("perf_stl", 1'b0, 4'b0100, 32'h0, 32'h0,    6'b001111, 1'b0, 32'h0, 1'b0);
      end
      step("perf_fl",    1'b0, 4'b0000, 32'h8,  32'h0,    6'b000000, 1'b1, 32'h20, 1'b0);
      step("perf_rf",    1'b0, 4'b0000, 32'h0,  32'h0,    6'b000000, 1'b0, 32'h0, 1'b1);
      checks++;
      assert (stall_cycles_o === 32'd5) else begin
         errors++;
         $error("FAIL perf.stall_cycles: observed %0d expected 5", stall_cycles_o);
      end
      checks++;
      assert (flush_count_o === 32'd1) else begin
         errors++;
         $error("FAIL perf.flush_count: observed %0d expected 1", flush_count_o);
      end
`endif

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stall_flush_ctrl.md
STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 SHALL have parameter REFILL_CYCLES, default 2, meaning post-flush exception-mask window in cycles (legal 1..15).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high (`RstEnable`).
REQ-004 SHALL have port stallreq_from_if, input, 1, instruction-bus stall request.
REQ-005 SHALL have port stallreq_from_id, input, 1, decode-stage stall request.
REQ-006 SHALL have port stallreq_from_ex, input, 1, execute-stage stall request (multi-cycle mul/div).
REQ-007 SHALL have port stallreq_from_mem, input, 1, data-bus stall request.
REQ-008 SHALL have port excepttype_i, input, 32, exception code from MEM stage; zero means none.
REQ-009 SHALL have port cp0_epc_i, input, 32, current CP0 EPC.
REQ-010 SHALL have port stall, output, 6, per-stage stall vector (bit0 PC ... bit5 WB); 1 = `Stop`.
REQ-011 SHALL have port flush, output, 1, pipeline-register flush.
REQ-012 SHALL have port new_pc, output, 32, redirect target, valid while flush=1.
REQ-013 SHALL have port refill_o, output, 1, high while in REFILL state.

Function
REQ-014 SHALL implement FSM states RUN and REFILL plus a 4-bit refill counter.
REQ-015 In RUN with excepttype_i≠0: flush=1 and stall=6'b000000 in the same cycle (combinational), next state REFILL, counter loads REFILL_CYCLES-1.
REQ-016 new_pc SHALL be cp0_epc_i for excepttype 32'h0000000e (eret), 32'h00000020 for any other nonzero code, and `ZeroWord` when flush=0.
REQ-017 In RUN with excepttype_i=0, stall SHALL be combinational, priority mem>ex>id>if: 6'b011111, 6'b001111, 6'b000111, 6'b000011; none -> 6'b000000.
REQ-018 In REFILL: flush=0, excepttype_i ignored, stall per REQ-017, counter decrements each cycle; at 0 next state RUN.
REQ-019 Counter SHALL decrement even while stall≠0 (window counts clock cycles, not advancing instructions).
REQ-020 Exception simultaneous with any stall request SHALL win: flush=1, stall=0.
REQ-021 Exception on the first RUN cycle after REFILL SHALL be accepted normally.

Reset
REQ-022 With rst=1 at a clock edge: state RUN, counter 0, refill_o=0; while rst=1 outputs stall=0, flush=0, new_pc=`ZeroWord` regardless of inputs.
REQ-023 Reset asserted during REFILL SHALL abort the window at that edge.

Configuration
REQ-024 Macro STALL_PERF_CNT_EN: when defined, SHALL add outputs stall_cycles_o[31:0] (increments each cycle stall≠0) and flush_count_o[31:0] (increments each flush=1 cycle), both wrapping at 2^32 and cleared by reset; when undefined these ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-025 Stall encodings, exception codes (eret 32'h0000000e), exception vector 32'h00000020 and FSM state encodings SHALL live in the shared defines package.
REQ-026 Priority stall encoder SHALL be sub-module stall_encoder (combinational); FSM/counters stay in stall_flush_ctrl.

Verification
REQ-027 stallreq_from_ex=1, others 0, RUN -> stall=6'b001111, flush=0 same cycle.
REQ-028 All four requests=1 -> stall=6'b011111.
REQ-029 excepttype_i=32'h0000000e, cp0_epc_i=32'h00001234, stallreq_from_mem=1 -> flush=1, new_pc=32'h00001234, stall=0; next 2 cycles refill_o=1.
REQ-030 excepttype_i=32'h00000008 held 4 cycles, REFILL_CYCLES=2 -> flush=1 in cycle 0 only, refill_o in cycles 1-2, flush=1 again in cycle 3.
REQ-031 rst=1 in first REFILL cycle -> next cycle refill_o=0, excepttype_i=32'h0000000c -> flush=1, new_pc=32'h00000020.
REQ-032 With STALL_PERF_CNT_EN: 5 stalled cycles, 1 flush -> stall_cycles_o=5, flush_count_o=1.
